// File: rtl/poly_mixer.sv
// poly_mixer: multi-channel gain/mute audio mixer.
//
// On a sample strobe in idle the block snapshots all channel samples, gains and mutes,
// then accumulates one channel per cycle (sample * gain, rescaled by 2^(GW-1)).
// After the last channel it emits (acc >>> SHIFT), reduced to DW bits, with a
// one-cycle valid pulse.
//
// Build option:
//   MIXER_SATURATE_EN  defined   -> width reduction clamps to the DW-bit signed range
//                      undefined -> width reduction keeps the low DW bits (wraps)
//
// Ports:
//   clk           mix clock, rising edge
//   rst_n         asynchronous active-low reset
//   sample_stb_i  one-cycle strobe that starts a mix (ignored while busy)
//   snd_i         packed signed samples, channel k at [k*DW +: DW]
//   gain_i        packed unsigned Q1.(GW-1) gains, channel k at [k*GW +: GW]
//   mute_i        per-channel mute, bit k=1 removes channel k from the sum
//   data_o        signed mixed sample, held between mixes
//   valid_o       one-cycle pulse when data_o updates
//   busy_o        high while a mix is in progress
//   overrun_o     one-cycle pulse when a strobe arrives while busy
module poly_mixer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DW     = 16,
  parameter int unsigned GW     = 8,
  parameter int unsigned SHIFT  = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_stb_i,
  input  logic [NUM_CH*DW-1:0] snd_i,
  input  logic [NUM_CH*GW-1:0] gain_i,
  input  logic [NUM_CH-1:0]    mute_i,
  output logic [DW-1:0]        data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int unsigned IW = $clog2(NUM_CH);
  // Worst case sum of NUM_CH products fits with one spare sign bit.
  localparam int unsigned AW = DW + GW + $clog2(NUM_CH) + 1;
  localparam int unsigned PW = DW + GW + 1;
  localparam logic [IW-1:0] LastIdx = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_CH*DW-1:0]  snd_q, snd_d;
  logic [NUM_CH*GW-1:0]  gain_q, gain_d;
  logic [NUM_CH-1:0]     mute_q, mute_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  valid_q, valid_d;

  logic signed [DW-1:0]  cur_snd;
  logic [GW-1:0]         cur_gain;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  term;
  logic signed [AW-1:0]  term_ext;
  logic [DW-1:0]         reduced;

  // Current channel's scaled contribution. Gain is zero-extended so the product stays
  // signed; >>> floors toward negative infinity.
  always_comb begin
    cur_snd  = snd_q[idx_q*DW +: DW];
    cur_gain = gain_q[idx_q*GW +: GW];
    prod     = cur_snd * $signed({1'b0, cur_gain});
    term     = prod >>> (GW - 1);
    term_ext = {{(AW - PW){term[PW-1]}}, term};
  end

`ifdef MIXER_SATURATE_EN
  localparam logic signed [AW-1:0] SatMax = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW-1:0] SatMin = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  logic signed [AW-1:0] shifted;

  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (shifted > SatMax) begin
      reduced = SatMax[DW-1:0];
    end else if (shifted < SatMin) begin
      reduced = SatMin[DW-1:0];
    end else begin
      reduced = shifted[DW-1:0];
    end
  end
`else
  // Low DW bits of (acc >>> SHIFT) are simply acc bits [SHIFT +: DW].
  always_comb begin
    reduced = acc_q[SHIFT +: DW];
  end
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    snd_d   = snd_q;
    gain_d  = gain_q;
    mute_d  = mute_q;
    data_d  = data_q;
    valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (sample_stb_i) begin
          snd_d   = snd_i;
          gain_d  = gain_i;
          mute_d  = mute_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (!mute_q[idx_q]) begin
          acc_d = acc_q + term_ext;
        end
        if (idx_q == LastIdx) begin
          state_d = StOut;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StOut: begin
        data_d  = reduced;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      idx_q   <= '0;
      snd_q   <= '0;
      gain_q  <= '0;
      mute_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      snd_q   <= snd_d;
      gain_q  <= gain_d;
      mute_q  <= mute_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q != StIdle);
  // Strobes while busy are dropped; flag them in the same cycle.
  assign overrun_o = sample_stb_i & busy_o;

endmodule
